// File: rtl/mvm_frame_tx.sv
// Replays preloaded matrix/vector frames from a word buffer over a valid/ready stream.
// Every output is registered; the buffer is writable only while idle.
module mvm_frame_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 3,
  parameter int unsigned FRAME = SIZE * SIZE + 2 * SIZE,
  parameter int unsigned MAXF  = 5,
  parameter int unsigned AW    = $clog2(FRAME * MAXF)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         start,
  input  logic [$clog2(MAXF+1)-1:0]    num_frames,
  input  logic                         throttle,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             data_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         done
);

  localparam int unsigned DEPTH = FRAME * MAXF;
  localparam int unsigned NW    = $clog2(MAXF + 1);
  localparam int unsigned PW    = $clog2(FRAME);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t           state, state_n;
  logic [AW-1:0]    rd_ptr, rd_ptr_n;
  logic [PW-1:0]    wpos, wpos_n;
  logic [NW-1:0]    fcnt, fcnt_n;
  logic [NW-1:0]    n_lat, n_lat_n;
  logic [NW-1:0]    n_clamp;
  logic             valid_n, busy_n, frame_done_n, done_n;
  logic [WIDTH-1:0] data_n;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_word;
  logic             wr_ok;
  logic             hs;
  logic             frame_end;
  logic             last_word;

  logic [WIDTH-1:0] mem [DEPTH];

  // Buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Address of the word to load into data_out; same-cycle writes bypass the array.
  always_comb begin
    wr_ok = (state == IDLE) && wr_en && (32'(wr_addr) < DEPTH);
    hs    = m_valid && m_ready;
    case (state)
      SEND:    rd_addr = hs ? rd_ptr + AW'(1) : rd_ptr;
      default: rd_addr = '0;
    endcase
    if (wr_ok && (wr_addr == rd_addr)) rd_word = wr_data;
    else if (32'(rd_addr) < DEPTH)     rd_word = mem[rd_addr];
    else                               rd_word = '0;
  end

  always_comb begin
    n_clamp   = (num_frames > NW'(MAXF)) ? NW'(MAXF) : num_frames;
    frame_end = (wpos == PW'(FRAME - 1));
    last_word = frame_end && (fcnt == n_lat - NW'(1));
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n      = state;
    rd_ptr_n     = rd_ptr;
    wpos_n       = wpos;
    fcnt_n       = fcnt;
    n_lat_n      = n_lat;
    valid_n      = m_valid;
    data_n       = data_out;
    busy_n       = busy;
    frame_done_n = 1'b0;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (start) begin
          n_lat_n  = n_clamp;
          rd_ptr_n = '0;
          wpos_n   = '0;
          fcnt_n   = '0;
          busy_n   = 1'b1;
          if (n_clamp == '0) begin
            state_n = DRAIN;
          end else begin
            state_n = SEND;
            valid_n = !throttle;
            data_n  = rd_word;
          end
        end
      end
      SEND: begin
        if (hs) begin
          if (frame_end) begin
            frame_done_n = 1'b1;
            wpos_n       = '0;
            fcnt_n       = fcnt + NW'(1);
          end else begin
            wpos_n = wpos + PW'(1);
          end
          if (last_word) begin
            state_n = DRAIN;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            rd_ptr_n = rd_ptr + AW'(1);
            valid_n  = !throttle;
            data_n   = rd_word;
          end
        end else if (!m_valid) begin
          valid_n = !throttle;
          data_n  = rd_word;
        end
      end
      DRAIN: begin
        // A zero-frame request arrives here without done set and waits one extra cycle.
        valid_n = 1'b0;
        if (done) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          done_n = 1'b1;
          busy_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wpos       <= '0;
      fcnt       <= '0;
      n_lat      <= '0;
      m_valid    <= 1'b0;
      data_out   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      rd_ptr     <= rd_ptr_n;
      wpos       <= wpos_n;
      fcnt       <= fcnt_n;
      n_lat      <= n_lat_n;
      m_valid    <= valid_n;
      data_out   <= data_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_mvm_frame_tx.sv
// Directed bench for mvm_frame_tx: replay order, backpressure, throttle,
// frame-count edges, ignored inputs and mid-transfer reset.
module tb_mvm_frame_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned FRAME = 15;
  localparam int unsigned MAXF  = 5;
  localparam int unsigned DEPTH = FRAME * MAXF;
  localparam int unsigned AW    = 7;
  localparam int unsigned NW    = 3;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [NW-1:0]    num_frames;
  logic             throttle;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             frame_done;
  logic             done;

  logic [WIDTH-1:0] exp_mem [DEPTH];
  int passed;
  int total;

  mvm_frame_tx dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .num_frames (num_frames),
    .throttle   (throttle),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic write_word(input int addr, input logic [WIDTH-1:0] val);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = val;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input int nf);
    start      = 1'b1;
    num_frames = NW'(nf);
    step();
    start      = 1'b0;
  endtask

  // Drives ready/throttle per cycle from the cycle after start and checks the stream.
  task automatic run_xfer(input int nwords, input int nfr, input bit rnd_ready,
                          input bit rnd_thr, input int exp_cycles);
    int k, c, fd;
    bit fin, pv, pr;
    logic [WIDTH-1:0] pd;
    k = 0; c = 1; fd = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
    while (!fin && c < 2000) begin
      if (pv && !pr) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'(pd));
      end
      if (frame_done) fd++;
      if (done) begin
        fin = 1'b1;
        check("last_frame_done", 32'(frame_done), (nfr > 0) ? 32'd1 : 32'd0);
        check("valid_at_done", 32'(m_valid), 32'd0);
        check("busy_at_done", 32'(busy), 32'd1);
      end else begin
        m_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        throttle = rnd_thr ? 1'($urandom_range(0, 1)) : 1'b0;
        if (m_valid && m_ready) begin
          check("word", 32'(data_out), 32'(exp_mem[k]));
          k++;
        end
        pv = m_valid; pr = m_ready; pd = data_out;
        step();
        c++;
      end
    end
    check("finished", 32'(fin), 32'd1);
    check("word_count", 32'(k), 32'(nwords));
    check("frame_done_count", 32'(fd), 32'(nfr));
    if (exp_cycles >= 0) check("cycles", 32'(c), 32'(exp_cycles));
    throttle = 1'b0;
    m_ready  = 1'b1;
    step();
    check("busy_after", 32'(busy), 32'd0);
    check("done_single", 32'(done), 32'd0);
    check("frame_done_after", 32'(frame_done), 32'd0);
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; num_frames = '0; throttle = 1'b0; m_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    step();

    // Single frame of 0x01..0x0F, full rate.
    for (int i = 0; i < int'(FRAME); i++) begin
      exp_mem[i] = WIDTH'(i + 1);
      write_word(i, exp_mem[i]);
    end
    m_ready = 1'b1;
    do_start(1);
    run_xfer(15, 1, 1'b0, 1'b0, 16);

    // Five frames, value = address, random backpressure.
    for (int i = 0; i < int'(DEPTH); i++) begin
      exp_mem[i] = WIDTH'(i);
      write_word(i, exp_mem[i]);
    end
    do_start(5);
    run_xfer(75, 5, 1'b1, 1'b0, -1);

    // Random throttle, then full-rate timing for three frames.
    do_start(2);
    run_xfer(30, 2, 1'b0, 1'b1, -1);
    do_start(3);
    run_xfer(45, 3, 1'b0, 1'b0, 46);

    // Frame-count edges: zero and clamped.
    do_start(0);
    run_xfer(0, 0, 1'b0, 1'b0, 2);
    do_start(7);
    run_xfer(75, 5, 1'b0, 1'b0, 76);

    // Write and start while sending are ignored.
    m_ready = 1'b0;
    do_start(1);
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'hAA;
    start = 1'b1; num_frames = NW'(5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ign_valid", 32'(m_valid), 32'd1);
      check("ign_data", 32'(data_out), 32'h00);
    end
    wr_en = 1'b0; start = 1'b0;
    run_xfer(15, 1, 1'b0, 1'b0, -1);
    write_word(80, 8'h55);
    do_start(1);
    run_xfer(15, 1, 1'b0, 1'b0, 16);

    // Write to word 0 in the same cycle as start.
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h33;
    exp_mem[0] = 8'h33;
    do_start(1);
    wr_en = 1'b0;
    run_xfer(15, 1, 1'b0, 1'b0, 16);

    // Reset after word 7 is accepted, then replay from word 0.
    m_ready = 1'b1;
    do_start(1);
    for (int i = 0; i < 8; i++) begin
      check("pre_rst_word", 32'(data_out), 32'(exp_mem[i]));
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    step();
    check("midrst_done_later", 32'(done), 32'd0);
    do_start(1);
    run_xfer(15, 1, 1'b0, 1'b0, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mvm_frame_tx.md
Name: mvm_frame_tx

Overview:
- Stream transmitter that feeds the matrix-vector multiplier's input port over the team's valid/ready handshake.
- A host preloads a word buffer holding up to MAXF frames. One frame is SIZE*SIZE matrix words followed by 2*SIZE vector words.
- On start, the block replays the requested number of frames with a gap-free handshake.
- An optional throttle input inserts idle cycles so the bench can stress the DUT's ready logic in hardware.

Parameters:
- WIDTH, 8, data word width in bits (signed; passed through unmodified).
- SIZE, 3, matrix dimension.
- FRAME, SIZE*SIZE+2*SIZE (15), words per frame.
- MAXF, 5, maximum frames held; buffer depth is FRAME*MAXF (75).
- AW, $clog2(FRAME*MAXF), address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous active-low reset; reset=0 at a rising edge resets the block.
- wr_en  in  1  buffer write strobe; honoured only in IDLE.
- wr_addr  in  AW  buffer write address; addresses >= FRAME*MAXF are ignored.
- wr_data  in  WIDTH  buffer write data.
- start  in  1  single-cycle start request; honoured only in IDLE.
- num_frames  in  $clog2(MAXF+1)  frame count, sampled when start is accepted.
- throttle  in  1  when 1, suppresses presentation of a new word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- data_out  out  WIDTH  output word.
- busy  out  1  high in SEND and DRAIN.
- frame_done  out  1  one-cycle pulse per completed frame.
- done  out  1  one-cycle pulse when the whole transfer completes.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-low. Every output is registered.
- Reset values:
  - m_valid=0, data_out=0, busy=0, frame_done=0, done=0.
  - State=IDLE; read pointer, word counter and frame counter all 0.
  - Buffer contents are not reset.
- Reset mid-transfer aborts the transfer. m_valid drops on the reset edge and no frame_done or done pulse is produced.
- States:
  - IDLE:
    - Writes are accepted.
    - start=1 latches n = min(num_frames, MAXF).
    - If n=0: go to DRAIN, pulse done the next cycle, then return to IDLE.
    - Otherwise: go to SEND with rd_ptr=0.
  - SEND:
    - Present buffer[rd_ptr] on data_out with m_valid=1, unless throttle=1 and no word is currently presented.
    - The first word appears on the cycle after start is accepted, provided throttle=0.
    - On m_valid & m_ready: rd_ptr++. The next word is presented on the following cycle with no bubble (1 word/clk under continuous ready and throttle=0).
    - After a transfer, if throttle=1 on that edge, m_valid goes 0 until throttle falls.
  - DRAIN:
    - Entered after the handshake of word FRAME*n-1.
    - m_valid=0; done pulses for one cycle; next state is IDLE.
- Handshake rules:
  - Once m_valid=1, it stays 1 and data_out stays stable until accepted. throttle never withdraws a presented word.
  - m_valid never depends combinationally on m_ready.
- Frame boundary:
  - frame_done pulses the cycle after the handshake of each word whose index mod FRAME = FRAME-1, including the last frame.
  - For the last frame, done and frame_done are asserted in the same cycle.
- Ignored inputs:
  - wr_en outside IDLE is ignored (buffer is read-stable during a transfer).
  - start outside IDLE is ignored.
- Writes:
  - wr_en in the same IDLE cycle as start is performed.
  - A word written that cycle is visible if it is later read.
- Counter widths: word counter counts to FRAME*MAXF-1 with no wrap. Frame counter counts to MAXF.
- busy is 1 from the cycle after start is accepted through the done-pulse cycle.

Test Plan:
- Basic single frame:
  - Stimulus: load words 0x01..0x0F at addresses 0..14; start with num_frames=1; m_ready=1; throttle=0.
  - Required response: m_valid high for exactly 15 consecutive cycles with data_out 0x01..0x0F in order.
  - frame_done and done pulse together 1 cycle after the last handshake; busy=0 afterwards.
- Backpressure:
  - Stimulus: 5 frames (75 words, value = address); random m_ready at 50%.
  - Required response: every word is seen exactly once, in order 0x00..0x4A.
  - data_out is stable while m_valid=1 and m_ready=0; 5 frame_done pulses; 1 done pulse.
- Throttle:
  - Stimulus: random throttle; m_ready=1.
  - Required response: m_valid never falls without a handshake; sequence correct.
  - With throttle=0 and m_ready=1 the cycle count is exactly 15*n+1 from start to done.
- Edge counts:
  - num_frames=0: done pulses 2 cycles after start; m_valid stays 0.
  - num_frames=7: clamped to 5 (75 words).
- Ignored inputs:
  - Stimulus: wr_en to address 0 with 0xAA during SEND; a second start during SEND; a write to address 80.
  - Required response: none of these has any effect.
  - A subsequent run still outputs the original word 0 value.
- Reset mid-transfer:
  - Stimulus: reset=0 for 1 cycle after word 7 is accepted.
  - Required response: on the next edge m_valid=0, busy=0, no done pulse.
  - A new start replays from word 0.
